if_pipe_ctrl: RTL and testbench

//   Consumer side of the hazard/stall interface. Owns the PC register, the IF/ID

---
 rtl/if_pipe_ctrl.sv | 148 ++++++++++++++
 tb/tb_if_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_pipe_ctrl.sv
// if_pipe_ctrl: PC, IF/ID and ID/EX control registers applying hold/bubble/flush from the hazard unit.
// Latency: every input takes effect on the next rising clk edge; async active-high reset.
// Backpressure: pcwrite/ifdwrite hold their stage; redirect and squash override the holds.
// Optional: define PIPE_PERF_EN to add saturating stall/bubble/flush event counters.
module if_pipe_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 9,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcwrite,
  input  logic              ifdwrite,
  input  logic              bubble,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [31:0]       imem_addr,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc4,
  output logic              ifid_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              idex_valid
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic [31:0]       ifid_pc4_q, ifid_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic              idex_valid_q, idex_valid_d;
  logic [31:0]       pc_plus4;
  logic              squash;

  // Sequential PC wraps naturally in 32 bits; a taken branch also squashes the fetched slot.
  assign pc_plus4 = pc_q + 32'd4;
  assign squash   = flush | branch_taken;

  // PC next-state: redirect beats stall, stall beats sequential advance
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (!pcwrite) begin
      pc_d = pc_plus4;
    end
  end

  // IF/ID next-state: squash beats hold, hold beats load
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (squash) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (!ifdwrite) begin
      ifid_instr_d = imem_instr;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  // ID/EX next-state: a bubble zeroes the control bundle and marks the slot empty
  always_comb begin
    idex_ctrl_d  = id_ctrl;
    idex_valid_d = ifid_valid_q;
    if (bubble) begin
      idex_ctrl_d  = '0;
      idex_valid_d = 1'b0;
    end
  end

  // Pipeline register bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_valid_q <= idex_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;
  assign idex_ctrl  = idex_ctrl_q;
  assign idex_valid = idex_valid_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; each sticks at all-ones instead of wrapping
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (pcwrite && !branch_taken && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
    if (squash && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
      flush_cnt_q  <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_pipe_ctrl.sv
// Bench for if_pipe_ctrl: directed vector table, reset/stall corner cases, randomized run vs reference model.
module tb_if_pipe_ctrl;
  localparam int CTRL_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              pcwrite, ifdwrite, bubble, flush, branch_taken;
  logic [31:0]       branch_target, imem_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       imem_addr, ifid_instr, ifid_pc4;
  logic              ifid_valid, idex_valid;
  logic [CTRL_W-1:0] idex_ctrl;
`ifdef PIPE_PERF_EN
  logic [31:0]       stall_cnt, bubble_cnt, flush_cnt;
`endif

  if_pipe_ctrl #(.RESET_PC(32'h0), .CTRL_W(CTRL_W), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .pcwrite(pcwrite), .ifdwrite(ifdwrite), .bubble(bubble),
    .flush(flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_instr(imem_instr), .id_ctrl(id_ctrl), .imem_addr(imem_addr),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .idex_ctrl(idex_ctrl), .idex_valid(idex_valid)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model state: what each architectural register should hold.
  logic [31:0]       m_pc, m_ins, m_pc4;
  logic              m_v, m_iv;
  logic [CTRL_W-1:0] m_ctrl;
  logic [31:0]       m_stall, m_bub, m_fl;

  task automatic model_reset();
    m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_v = 1'b0;
    m_ctrl = '0; m_iv = 1'b0;
    m_stall = 0; m_bub = 0; m_fl = 0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (!en) return v;
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".imem_addr"}, imem_addr, m_pc);
    chk({tag, ".ifid_instr"}, ifid_instr, m_ins);
    chk({tag, ".ifid_pc4"}, ifid_pc4, m_pc4);
    chk({tag, ".ifid_valid"}, {31'b0, ifid_valid}, {31'b0, m_v});
    chk({tag, ".idex_ctrl"}, {23'b0, idex_ctrl}, {23'b0, m_ctrl});
    chk({tag, ".idex_valid"}, {31'b0, idex_valid}, {31'b0, m_iv});
`ifdef PIPE_PERF_EN
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".bubble_cnt"}, bubble_cnt, m_bub);
    chk({tag, ".flush_cnt"}, flush_cnt, m_fl);
`endif
  endtask

  // One clock: predict from the current inputs, take the edge, then optionally compare.
  task automatic tick(input bit do_chk, input string tag);
    logic [31:0]       n_pc, n_ins, n_pc4;
    logic              n_v, n_iv;
    logic [CTRL_W-1:0] n_ctrl;
    n_pc = branch_taken ? (branch_target & 32'hFFFF_FFFC)
         : pcwrite      ? m_pc : m_pc + 32'd4;
    if (flush || branch_taken) begin
      n_ins = 32'h0; n_pc4 = 32'h0; n_v = 1'b0;
    end else if (ifdwrite) begin
      n_ins = m_ins; n_pc4 = m_pc4; n_v = m_v;
    end else begin
      n_ins = imem_instr; n_pc4 = m_pc + 32'd4; n_v = 1'b1;
    end
    n_ctrl = bubble ? '0 : id_ctrl;
    n_iv   = bubble ? 1'b0 : m_v;
    m_stall = sat_inc(m_stall, pcwrite && !branch_taken);
    m_bub   = sat_inc(m_bub, bubble);
    m_fl    = sat_inc(m_fl, flush || branch_taken);
    @(posedge clk); #1;
    m_pc = n_pc; m_ins = n_ins; m_pc4 = n_pc4; m_v = n_v; m_ctrl = n_ctrl; m_iv = n_iv;
    if (do_chk) check_model(tag);
  endtask

  task automatic set_in(input logic pw, input logic fw, input logic bb, input logic fl,
                        input logic bt, input logic [31:0] tgt, input logic [31:0] ins,
                        input logic [CTRL_W-1:0] ctl);
    pcwrite = pw; ifdwrite = fw; bubble = bb; flush = fl; branch_taken = bt;
    branch_target = tgt; imem_instr = ins; id_ctrl = ctl;
  endtask

  typedef struct {
    logic pw, fw, bb, fl, bt;
    logic [31:0] tgt, ins;
    logic [CTRL_W-1:0] ctl;
    logic [31:0] e_pc, e_ins, e_pc4;
    logic e_v;
    logic [CTRL_W-1:0] e_ctrl;
    logic e_iv;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Directed sequence from reset: idle, load-use, branch, stall+flush, wrap, inconsistent holds.
    vecs[0]  = '{0,0,0,0,0, 32'h0,         32'h1000_00A0, 9'h011, 32'h4,         32'h1000_00A0, 32'h4,   1, 9'h011, 0};
    vecs[1]  = '{0,0,0,0,0, 32'h0,         32'h1000_00A1, 9'h022, 32'h8,         32'h1000_00A1, 32'h8,   1, 9'h022, 1};
    vecs[2]  = '{0,0,0,0,0, 32'h0,         32'h1000_00A2, 9'h033, 32'hC,         32'h1000_00A2, 32'hC,   1, 9'h033, 1};
    vecs[3]  = '{0,0,0,0,0, 32'h0,         32'h1000_00A3, 9'h044, 32'h10,        32'h1000_00A3, 32'h10,  1, 9'h044, 1};
    vecs[4]  = '{1,1,1,0,0, 32'h0,         32'h1000_00A4, 9'h055, 32'h10,        32'h1000_00A3, 32'h10,  1, 9'h000, 0};
    vecs[5]  = '{0,0,0,0,0, 32'h0,         32'h1000_00A4, 9'h066, 32'h14,        32'h1000_00A4, 32'h14,  1, 9'h066, 1};
    vecs[6]  = '{1,0,0,0,1, 32'h103,       32'h1000_00A5, 9'h077, 32'h100,       32'h0,         32'h0,   0, 9'h077, 1};
    vecs[7]  = '{0,0,0,0,0, 32'h0,         32'h1000_00A6, 9'h088, 32'h104,       32'h1000_00A6, 32'h104, 1, 9'h088, 0};
    vecs[8]  = '{0,1,0,1,0, 32'h0,         32'h1000_00A7, 9'h099, 32'h108,       32'h0,         32'h0,   0, 9'h099, 1};
    vecs[9]  = '{0,0,0,0,1, 32'hFFFF_FFFE, 32'h1000_00A8, 9'h0AA, 32'hFFFF_FFFC, 32'h0,         32'h0,   0, 9'h0AA, 0};
    vecs[10] = '{0,0,0,0,0, 32'h0,         32'h1000_00A9, 9'h0BB, 32'h0,         32'h1000_00A9, 32'h0,   1, 9'h0BB, 0};
    vecs[11] = '{1,0,0,0,0, 32'h0,         32'h1000_00AA, 9'h1CC, 32'h0,         32'h1000_00AA, 32'h4,   1, 9'h1CC, 1};
    vecs[12] = '{0,1,0,0,0, 32'h0,         32'h1000_00AB, 9'h1DD, 32'h4,         32'h1000_00AA, 32'h4,   1, 9'h1DD, 1};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h0, '0);
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].pw, vecs[i].fw, vecs[i].bb, vecs[i].fl, vecs[i].bt,
             vecs[i].tgt, vecs[i].ins, vecs[i].ctl);
      tick(1'b0, "vec");
      chk($sformatf("vec%0d.imem_addr", i), imem_addr, vecs[i].e_pc);
      chk($sformatf("vec%0d.ifid_instr", i), ifid_instr, vecs[i].e_ins);
      chk($sformatf("vec%0d.ifid_pc4", i), ifid_pc4, vecs[i].e_pc4);
      chk($sformatf("vec%0d.ifid_valid", i), {31'b0, ifid_valid}, {31'b0, vecs[i].e_v});
      chk($sformatf("vec%0d.idex_ctrl", i), {23'b0, idex_ctrl}, {23'b0, vecs[i].e_ctrl});
      chk($sformatf("vec%0d.idex_valid", i), {31'b0, idex_valid}, {31'b0, vecs[i].e_iv});
    end

    // Asynchronous reset in the middle of a stall at PC=0x40.
    set_in(0, 0, 0, 0, 1, 32'h40, 32'h2000_0001, 9'h0F0);
    tick(1'b1, "to40");
    set_in(1, 1, 0, 0, 0, 32'h0, 32'h2000_0002, 9'h0F1);
    tick(1'b1, "stall40");
    chk("stall40.pc", imem_addr, 32'h40);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("midreset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrel.pc", imem_addr, 32'h0);
    set_in(0, 0, 0, 0, 0, 32'h0, 32'h2000_0003, 9'h0F2);
    tick(1'b1, "postrel");
    chk("postrel.pc_step", imem_addr, 32'h4);

`ifdef PIPE_PERF_EN
    // Event counters: 5 stalls, 2 flushes, 3 bubbles after a fresh reset.
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0, 0, 0, 32'h0, 32'h0, 9'h001);
      tick(1'b1, "pstall");
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 1, 0, 32'h0, 32'h0, 9'h002);
      tick(1'b1, "pflush");
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 0, 0, 32'h0, 32'h0, 9'h003);
      tick(1'b1, "pbub");
    end
    chk("perf.stall_cnt", stall_cnt, 32'd5);
    chk("perf.flush_cnt", flush_cnt, 32'd2);
    chk("perf.bubble_cnt", bubble_cnt, 32'd3);
`endif

    // Randomized traffic compared every cycle against the reference model.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
             ($urandom % 8) == 0, ($urandom % 8) == 0,
             (($urandom % 16) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom,
             $urandom, CTRL_W'($urandom));
      tick(1'b1, "rand");
    end

`ifdef PIPE_PERF_EN
    // Saturation: start stall_cnt just below all-ones and keep stalling.
    set_in(1, 1, 0, 0, 0, 32'h0, 32'h0, 9'h0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hFFFF_FFFD;
    for (int i = 0; i < 5; i++) tick(1'b1, "sat");
    chk("sat.stall_cnt", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case anything above stops advancing.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
